// File: rtl/alu_issue.sv
// alu_issue: RV32I OP/OP-IMM/LUI issue stage feeding a one-cycle registered ALU; optional ALU_ISSUE_FWD_EN forwards WB results
module alu_issue #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic [REG_AW-1:0] rs1_addr,
  output logic [REG_AW-1:0] rs2_addr,
  input  logic [XLEN-1:0]   rs1_data,
  input  logic [XLEN-1:0]   rs2_data,
  input  logic [XLEN-1:0]   alu_result,
  output logic              alu_i,
  output logic [XLEN-1:0]   alu_op0,
  output logic [XLEN-1:0]   alu_op1,
  output logic [3:0]        alu_opcode,
  output logic              wb_valid,
  output logic [REG_AW-1:0] wb_rd,
  output logic              illegal
);
  logic              alu_i_q, alu_i_d, wb_valid_q, wb_valid_d, illegal_q, illegal_d;
  logic [XLEN-1:0]   alu_op0_q, alu_op0_d, alu_op1_q, alu_op1_d;
  logic [3:0]        alu_opcode_q, alu_opcode_d;
  logic [REG_AW-1:0] ex_rd_q, ex_rd_d, wb_rd_q, wb_rd_d, rd;
  logic [6:0]        opc, f7;
  logic [2:0]        f3;
  logic              is_op, is_opi, is_lui, is_shift, legal, alt, accept;
  logic              ex_hit1, ex_hit2, wb_hit1, wb_hit2, use1, use2, hazard;
  logic [XLEN-1:0]   src1, src2, imm_i, imm_u, shamt;

  assign opc      = instr[6:0];
  assign f3       = instr[14:12];
  assign f7       = instr[31:25];
  assign rd       = REG_AW'(instr[11:7]);
  assign rs1_addr = REG_AW'(instr[19:15]);
  assign rs2_addr = REG_AW'(instr[24:20]);
  assign imm_i    = XLEN'($signed(instr[31:20]));
  assign imm_u    = XLEN'($signed({instr[31:12], 12'b0}));
  assign shamt    = XLEN'(instr[24:20]);

  // Decode legality, the 4-bit ALU opcode and which source registers are actually read
  always_comb begin
    is_op    = opc == 7'b0110011;
    is_opi   = opc == 7'b0010011;
    is_lui   = opc == 7'b0110111;
    is_shift = is_opi & (f3 == 3'b001 | f3 == 3'b101);
    legal    = is_lui
             | (is_op & (f7 == 7'b0 | (f7 == 7'b0100000 & (f3 == 3'b000 | f3 == 3'b101))))
             | (is_opi & (f3 == 3'b001 ? f7 == 7'b0 :
                          f3 == 3'b101 ? (f7 == 7'b0 | f7 == 7'b0100000) : 1'b1));
    alt      = instr[30] & ((f3 == 3'b000 & is_op) | f3 == 3'b101);
    use1     = (is_op | is_opi) & |rs1_addr;
    use2     = is_op & |rs2_addr;
  end

  // Source match against the instruction in EX and the result sitting in WB
  always_comb begin
    ex_hit1 = alu_i_q & ex_rd_q == rs1_addr;
    ex_hit2 = alu_i_q & ex_rd_q == rs2_addr;
    wb_hit1 = wb_valid_q & wb_rd_q == rs1_addr;
    wb_hit2 = wb_valid_q & wb_rd_q == rs2_addr;
  end

`ifdef ALU_ISSUE_FWD_EN
  // Only an EX match stalls; a WB match takes the ALU result directly
  always_comb begin
    hazard = instr_valid & ((use1 & ex_hit1) | (use2 & ex_hit2));
    src1   = wb_hit1 ? alu_result : rs1_data;
    src2   = wb_hit2 ? alu_result : rs2_data;
  end
`else
  logic unused_alu_result;
  assign unused_alu_result = ^alu_result;
  // Without forwarding, both EX and WB matches wait for the regfile write
  always_comb begin
    hazard = instr_valid & ((use1 & (ex_hit1 | wb_hit1)) | (use2 & (ex_hit2 | wb_hit2)));
    src1   = rs1_data;
    src2   = rs2_data;
  end
`endif

  assign instr_ready = !rst & !hazard;
  assign accept      = instr_valid & instr_ready;

  // Next operand/opcode registers load on accept; EX rd advances into WB with alu_i
  always_comb begin
    alu_i_d      = accept & legal;
    illegal_d    = accept & !legal;
    alu_op0_d    = accept ? (is_lui ? '0 : src1) : alu_op0_q;
    alu_op1_d    = accept ? (is_lui ? imm_u : is_op ? src2 : is_shift ? shamt : imm_i) : alu_op1_q;
    alu_opcode_d = accept ? (is_lui ? 4'b0000 : {f3, alt}) : alu_opcode_q;
    ex_rd_d      = accept ? rd : ex_rd_q;
    wb_valid_d   = alu_i_q;
    wb_rd_d      = alu_i_q ? ex_rd_q : wb_rd_q;
  end

  // Pipeline registers; reset discards everything in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_i_q      <= 1'b0;
      illegal_q    <= 1'b0;
      wb_valid_q   <= 1'b0;
      alu_op0_q    <= '0;
      alu_op1_q    <= '0;
      alu_opcode_q <= '0;
      ex_rd_q      <= '0;
      wb_rd_q      <= '0;
    end else begin
      alu_i_q      <= alu_i_d;
      illegal_q    <= illegal_d;
      wb_valid_q   <= wb_valid_d;
      alu_op0_q    <= alu_op0_d;
      alu_op1_q    <= alu_op1_d;
      alu_opcode_q <= alu_opcode_d;
      ex_rd_q      <= ex_rd_d;
      wb_rd_q      <= wb_rd_d;
    end
  end

  assign alu_i      = alu_i_q;
  assign illegal    = illegal_q;
  assign wb_valid   = wb_valid_q;
  assign alu_op0    = alu_op0_q;
  assign alu_op1    = alu_op1_q;
  assign alu_opcode = alu_opcode_q;
  assign wb_rd      = wb_rd_q;
endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
- Producer side of the ALU interface: accepts RV32I OP / OP-IMM / LUI instructions over a valid/ready handshake.
- Reads operands from the register file, encodes the 4-bit ALU opcode, and drives registered op0/op1/opcode plus the ALU enable.
- Tracks the destination register through the ALU's one-cycle registered latency and emits an aligned writeback tag.
- Stalls on read-after-write hazards against in-flight results.

Parameters:
- XLEN, 32, operand/result width
- REG_AW, 5, register address width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- instr  in  32  instruction word
- instr_valid  in  1  instr is valid
- instr_ready  out  1  block accepts instr this cycle
- rs1_addr  out  REG_AW  regfile read port 1 address; combinational from instr[19:15]
- rs2_addr  out  REG_AW  regfile read port 2 address; combinational from instr[24:20]
- rs1_data  in  XLEN  regfile read data 1, same cycle
- rs2_data  in  XLEN  regfile read data 2, same cycle
- alu_result  in  XLEN  ALU registered result
- alu_i  out  1  ALU enable; registered
- alu_op0  out  XLEN  ALU operand 0; registered
- alu_op1  out  XLEN  ALU operand 1; registered
- alu_opcode  out  4  ALU opcode; registered
- wb_valid  out  1  alu_result is valid for writeback this cycle
- wb_rd  out  REG_AW  writeback destination
- illegal  out  1  one-cycle pulse: unsupported instruction accepted

Behaviour:
- Reset (async, while rst=1): alu_i, wb_valid, illegal = 0; alu_op0, alu_op1, alu_opcode, wb_rd = 0; internal ex_rd = 0; instr_ready = 0.
- Accept: an instruction is accepted at the edge where instr_valid & instr_ready.
- Pipeline stages:
  - EX stage (alu_i=1) holds ex_rd.
  - WB stage: wb_valid=1 one cycle after alu_i, with wb_rd = previous ex_rd, aligned to alu_result.
- Latency: accepted at edge t -> alu_i=1 during cycle t+1 -> wb_valid=1 during cycle t+2. Throughput is one instruction per cycle when there is no hazard.
- Decode, opcode = instr[6:0]:
  - 0110011 (OP): op0=rs1_data, op1=rs2_data.
  - 0010011 (OP-IMM): op0=rs1_data, op1=sign-extended instr[31:20].
  - 0110111 (LUI): op0=0, op1={instr[31:12],12'b0}, ADD.
- funct3 -> alu_opcode:
  - 000 -> 0000 ADD, or 0001 SUB when OP and instr[30]=1.
  - 001 -> 0010 SLL
  - 010 -> 0100 SLT
  - 011 -> 0110 SLTU
  - 100 -> 1000 XOR
  - 101 -> 1010 SRL, or 1011 SRA when instr[30]=1.
  - 110 -> 1100 OR
  - 111 -> 1110 AND
- Illegal encodings:
  - any other major opcode;
  - OP with funct7 not 0000000, or not 0100000 for ADD/SUB and SRL/SRA;
  - OP-IMM shifts with instr[31:25] not 0000000, or not 0100000 for SRAI.
- Illegal handling: the instruction is accepted, illegal pulses 1 in cycle t+1, alu_i=0, nothing is written back.
- Hazard (RUN/STALL): STALL when instr_valid and the rs1 or rs2 in use (rs2 for OP only) is nonzero and equals:
  - ex_rd while alu_i=1, or
  - wb_rd while wb_valid=1.
- In STALL: instr_ready=0 and a bubble is issued (alu_i=0). The state returns to RUN when the condition clears. rd=x0 never creates a hazard.
- Stall duration: an EX match costs 2 stall cycles; a WB match costs 1. The regfile has no write-through.
- instr_ready = !rst & !hazard. Combinational; must not depend on instr_valid except through the hazard term.
- Reset mid-operation: in-flight EX and WB entries are discarded; wb_valid drops immediately.

Optional Feature:
- Macro: ALU_ISSUE_FWD_EN.
- Defined: a WB-stage match forwards alu_result into the operand register instead of stalling. Only an EX match stalls, for 1 cycle, after which the dependency is a WB match and is forwarded.
- Undefined: stall rules as above; the alu_result input is unused.

Test Plan:
- Reset mid-stream: assert rst while alu_i=1 -> alu_i, wb_valid, illegal = 0 immediately; instr_ready=0 until rst deasserts.
- ADD x3,x1,x2 with rs1_data=5, rs2_data=7 -> next cycle alu_i=1, opcode 0000, op0=5, op1=7; following cycle wb_valid=1, wb_rd=3.
- SRAI x4,x1,3 (instr[30]=1), then ADDI x5,x0,-1 -> opcode 1011 with op1=3; then opcode 0000 with op1=0xFFFFFFFF.
- LUI x6,0xABCDE -> op0=0, op1=0xABCDE000, opcode 0000.
- Dependent pair (ADD x3,x1,x2; SUB x4,x3,x1):
  - FWD off: instr_ready=0 for 2 cycles, then SUB is issued.
  - FWD on: 1 stall cycle, and SUB op0 equals alu_result.
- Illegal encoding 0x0000007F -> accepted, illegal=1 for one cycle, no alu_i, no wb_valid. Same for OP with funct7=0000001.
